eth_tx_framer: RTL and testbench

//  Transmit-side Ethernet framer for the phy_tx_clk domain: takes a byte stream of one MAC frame
//  (dest..payload, no FCS), emits preamble, SFD, data, zero pad, CRC-32 FCS and inter-frame gap.

---
 rtl/eth_pkg.sv | 22 ++
 rtl/crc32_d8.sv | 17 +
 rtl/eth_tx_framer.sv | 165 ++++++++++++++++
 tb/tb_eth_tx_framer.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared constants and state type for the Ethernet transmit framer and its CRC helper.
package eth_pkg;

    localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
    localparam logic [7:0]  ETH_SFD       = 8'hD5;
    localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [3:0] {
        TX_IDLE,
        TX_PRE,
        TX_SFD,
        TX_DATA,
        TX_PAD,
        TX_FCS,
        TX_ABORT,
        TX_DRAIN,
        TX_IFG
    } tx_state_t;

endpackage

// File: rtl/crc32_d8.sv
// Combinational byte-wide step of the reflected Ethernet CRC-32; also used by the RX checker.
module crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    always_comb begin
        crc_o = crc_i ^ {24'h000000, data_i};
        for (int i = 0; i < 8; i++) begin
            crc_o = crc_o[0] ? ((crc_o >> 1) ^ CRC32_POLY) : (crc_o >> 1);
        end
    end

endmodule

// File: rtl/eth_tx_framer.sv
// Transmit-side Ethernet framer: preamble, SFD, data, zero pad, CRC-32 FCS and inter-frame gap.
// Every pin is registered; the byte on the pins lags the state that produced it by one cycle.
module eth_tx_framer
    import eth_pkg::*;
#(
    parameter bit PAD_EN  = 1'b1,
    parameter int MIN_LEN = 60,
    parameter int MAX_LEN = 1514,
    parameter int IFG_LEN = 12
) (
    input  logic       phy_tx_clk,
    input  logic       phy_tx_reset_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [7:0] phy_tx_mux_data,
    output logic [1:0] phy_tx_mux_ctl,
    output logic       tx_done,
    output logic       tx_abort
);

    localparam logic [10:0] MinLenC  = 11'(MIN_LEN);
    localparam logic [10:0] MaxLenC  = 11'(MAX_LEN);
    localparam logic [3:0]  IfgLastC = 4'(IFG_LEN - 1);

    tx_state_t   state_q, state_d;
    logic [10:0] byteCnt_q, byteCnt_d;
    logic [3:0]  phase_q, phase_d;
    logic [31:0] crc_q, crc_d;
    logic        skipDrain_q, skipDrain_d;

    logic [7:0]  txData_q, txData_d;
    logic [1:0]  txCtl_q;
    logic        txEn_d, txEr_d;
    logic        inReady_q;
    logic        done_q, done_d;
    logic        abort_q, abort_d;

    logic [7:0]  crcByte;
    logic [31:0] crcNext;
    logic [31:0] fcs;

    // Pad bytes feed zeros into the CRC; data bytes feed the input stream.
    assign crcByte = (state_q == TX_PAD) ? 8'h00 : in_data;
    assign fcs     = ~crc_q;

    crc32_d8 u_crc (
        .crc_i  (crc_q),
        .data_i (crcByte),
        .crc_o  (crcNext)
    );

    always_comb begin
        state_d     = state_q;
        byteCnt_d   = byteCnt_q;
        phase_d     = phase_q + 4'd1;
        crc_d       = crc_q;
        skipDrain_d = skipDrain_q;
        txData_d    = 8'h00;
        txEn_d      = 1'b0;
        txEr_d      = 1'b0;
        done_d      = 1'b0;
        abort_d     = 1'b0;

        case (state_q)
            TX_IDLE: begin
                byteCnt_d = '0;
                crc_d     = CRC32_INIT;
                if (in_valid) state_d = TX_PRE;
            end
            TX_PRE: begin
                txData_d = ETH_PREAMBLE;
                txEn_d   = 1'b1;
                if (phase_q == 4'd6) state_d = TX_SFD;
            end
            TX_SFD: begin
                txData_d = ETH_SFD;
                txEn_d   = 1'b1;
                state_d  = TX_DATA;
            end
            TX_DATA: begin
                txEn_d = 1'b1;
                if (!in_valid) begin
                    txEr_d      = 1'b1;
                    abort_d     = 1'b1;
                    skipDrain_d = 1'b0;
                    state_d     = TX_ABORT;
                end else if (byteCnt_q == MaxLenC) begin
                    // Oversize byte is swallowed; if it also ends the frame there is nothing to drain.
                    txEr_d      = 1'b1;
                    abort_d     = 1'b1;
                    skipDrain_d = in_last;
                    state_d     = TX_ABORT;
                end else begin
                    txData_d  = in_data;
                    crc_d     = crcNext;
                    byteCnt_d = byteCnt_q + 11'd1;
                    if (in_last) begin
                        state_d = (PAD_EN && ((byteCnt_q + 11'd1) < MinLenC)) ? TX_PAD : TX_FCS;
                    end
                end
            end
            TX_PAD: begin
                txEn_d    = 1'b1;
                crc_d     = crcNext;
                byteCnt_d = byteCnt_q + 11'd1;
                if ((byteCnt_q + 11'd1) == MinLenC) state_d = TX_FCS;
            end
            TX_FCS: begin
                txEn_d   = 1'b1;
                txData_d = fcs[{phase_q[1:0], 3'b000} +: 8];
                if (phase_q == 4'd3) begin
                    done_d  = 1'b1;
                    state_d = TX_IFG;
                end
            end
            TX_ABORT: begin
                state_d = skipDrain_q ? TX_IFG : TX_DRAIN;
            end
            TX_DRAIN: begin
                if (in_valid && in_last) state_d = TX_IFG;
            end
            TX_IFG: begin
                if (phase_q == IfgLastC) state_d = TX_IDLE;
            end
            default: state_d = TX_IDLE;
        endcase

        if (state_d != state_q) phase_d = '0;
    end

    always_ff @(posedge phy_tx_clk or negedge phy_tx_reset_n) begin
        if (!phy_tx_reset_n) begin
            state_q     <= TX_IDLE;
            byteCnt_q   <= '0;
            phase_q     <= '0;
            crc_q       <= CRC32_INIT;
            skipDrain_q <= 1'b0;
            txData_q    <= 8'h00;
            txCtl_q     <= 2'b00;
            inReady_q   <= 1'b0;
            done_q      <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            byteCnt_q   <= byteCnt_d;
            phase_q     <= phase_d;
            crc_q       <= crc_d;
            skipDrain_q <= skipDrain_d;
            txData_q    <= txData_d;
            txCtl_q     <= {txEn_d ^ txEr_d, txEn_d};
            inReady_q   <= (state_d == TX_DATA) || (state_d == TX_DRAIN);
            done_q      <= done_d;
            abort_q     <= abort_d;
        end
    end

    assign in_ready        = inReady_q;
    assign phy_tx_mux_data = txData_q;
    assign phy_tx_mux_ctl  = txCtl_q;
    assign tx_done         = done_q;
    assign tx_abort        = abort_q;

endmodule

// File: tb/tb_eth_tx_framer.sv
// Scoreboard bench for eth_tx_framer: one padded instance (index 0) and one unpadded (index 1).
module tb_eth_tx_framer;

    localparam int IFG_LEN = 12;
    localparam int MIN_LEN = 60;
    localparam int MAX_LEN = 1514;

    logic clk = 1'b0;
    logic rstN;

    logic [7:0] inData  [2];
    logic       inValid [2];
    logic       inLast  [2];
    logic       inReady [2];
    logic [7:0] txData  [2];
    logic [1:0] txCtl   [2];
    logic       txDone  [2];
    logic       txAbort [2];

    // Expected pin words {abort, done, ctl[1:0], data[7:0]}, one queue per instance.
    logic [11:0] expQ0 [$];
    logic [11:0] expQ1 [$];
    logic [7:0]  frameBuf [$];

    int compared   = 0;
    int mismatched = 0;
    int cycle      = 0;
    int doneCycle  = 0;
    int gapLast    = 0;
    logic        prevActive = 1'b0;
    logic        inFrame    = 1'b0;
    logic [31:0] rxCrc      = 32'hFFFFFFFF;

    always #4 clk = ~clk;

    eth_tx_framer #(.PAD_EN(1'b1), .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .IFG_LEN(IFG_LEN)) dut (
        .phy_tx_clk      (clk),
        .phy_tx_reset_n  (rstN),
        .in_data         (inData[0]),
        .in_valid        (inValid[0]),
        .in_last         (inLast[0]),
        .in_ready        (inReady[0]),
        .phy_tx_mux_data (txData[0]),
        .phy_tx_mux_ctl  (txCtl[0]),
        .tx_done         (txDone[0]),
        .tx_abort        (txAbort[0])
    );

    eth_tx_framer #(.PAD_EN(1'b0), .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .IFG_LEN(IFG_LEN)) dutNoPad (
        .phy_tx_clk      (clk),
        .phy_tx_reset_n  (rstN),
        .in_data         (inData[1]),
        .in_valid        (inValid[1]),
        .in_last         (inLast[1]),
        .in_ready        (inReady[1]),
        .phy_tx_mux_data (txData[1]),
        .phy_tx_mux_ctl  (txCtl[1]),
        .tx_done         (txDone[1]),
        .tx_abort        (txAbort[1])
    );

    // Bit-serial reference CRC-32 (reflected), one input bit per step.
    function automatic logic [31:0] crcStep(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[0] ^ d[i];
            r  = {1'b0, r[31:1]};
            if (fb) r = r ^ 32'hEDB88320;
        end
        return r;
    endfunction

    function automatic int qSize(input int s);
        return (s == 0) ? expQ0.size() : expQ1.size();
    endfunction

    function automatic logic [11:0] qPop(input int s);
        if (s == 0) return expQ0.pop_front();
        return expQ1.pop_front();
    endfunction

    task automatic pushExp(input int s, input logic [11:0] w);
        if (s == 0) expQ0.push_back(w);
        else        expQ1.push_back(w);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Receiver-side view of instance 0: CRC over everything after the SFD must leave the residue,
    // and the idle run before each new frame start is measured for the back-to-back check.
    task automatic trackMain(input logic [11:0] act, input logic active);
        if (active && !prevActive) gapLast = cycle - doneCycle - 1;
        prevActive = active;
        if (act[9:8] == 2'b11) begin
            if (inFrame) rxCrc = crcStep(rxCrc, act[7:0]);
            else if (act[7:0] == 8'hD5) begin
                inFrame = 1'b1;
                rxCrc   = 32'hFFFFFFFF;
            end
        end else begin
            inFrame = 1'b0;
        end
        if (act[10]) begin
            doneCycle = cycle;
            checkOutput("residue", rxCrc, 32'hDEBB20E3);
            inFrame = 1'b0;
        end
    endtask

    task automatic monitorStep(input int s);
        logic [11:0] act;
        logic        active;
        act    = {txAbort[s], txDone[s], txCtl[s], txData[s]};
        active = (txCtl[s] != 2'b00) || txDone[s] || txAbort[s];
        if (s == 0) trackMain(act, active);
        if (active) begin
            if (qSize(s) == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL pins%0d: got %h, expected no output", s, act);
            end else begin
                checkOutput($sformatf("pins%0d", s), 32'(act), 32'(qPop(s)));
            end
        end
    endtask

    // Monitor: samples both instances on the falling edge, away from the registered updates.
    always @(negedge clk) begin
        cycle++;
        if (!rstN) begin
            inFrame    = 1'b0;
            prevActive = 1'b0;
        end else begin
            for (int s = 0; s < 2; s++) monitorStep(s);
        end
    end

    task automatic idleInputs(input int s);
        inData[s]  = 8'h00;
        inValid[s] = 1'b0;
        inLast[s]  = 1'b0;
    endtask

    // Presents one byte at a falling edge and returns at the falling edge after it was taken.
    task automatic applyStimulus(input int s, input logic [7:0] d, input logic last);
        int n;
        n = 0;
        inData[s]  = d;
        inValid[s] = 1'b1;
        inLast[s]  = last;
        while (inReady[s] !== 1'b1) begin
            @(negedge clk);
            n++;
            if (n > 4000) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL readyTimeout%0d: got no in_ready, expected in_ready within 4000 cycles", s);
                return;
            end
        end
        @(negedge clk);
    endtask

    task automatic buildFrame(input int len, input int seed);
        frameBuf.delete();
        for (int i = 0; i < len; i++) frameBuf.push_back(8'(seed + i * 3));
    endtask

    task automatic pushPre(input int s);
        for (int i = 0; i < 7; i++) pushExp(s, {2'b00, 2'b11, 8'h55});
        pushExp(s, {2'b00, 2'b11, 8'hD5});
    endtask

    task automatic pushFrame(input int s, input int underrunAt);
        logic [31:0] c;
        int          len;
        int          nData;
        c   = 32'hFFFFFFFF;
        len = frameBuf.size();
        pushPre(s);
        if (underrunAt > 0 || len > MAX_LEN) begin
            nData = (underrunAt > 0) ? underrunAt : MAX_LEN;
            for (int i = 0; i < nData; i++) pushExp(s, {2'b00, 2'b11, frameBuf[i]});
            pushExp(s, {1'b1, 1'b0, 2'b01, 8'h00});
        end else begin
            for (int i = 0; i < len; i++) begin
                pushExp(s, {2'b00, 2'b11, frameBuf[i]});
                c = crcStep(c, frameBuf[i]);
            end
            if (s == 0) begin
                for (int i = len; i < MIN_LEN; i++) begin
                    pushExp(s, {2'b00, 2'b11, 8'h00});
                    c = crcStep(c, 8'h00);
                end
            end
            c = ~c;
            for (int i = 0; i < 4; i++) pushExp(s, {1'b0, (i == 3), 2'b11, c[8 * i +: 8]});
        end
    endtask

    task automatic driveFrame(input int s, input int underrunAt);
        for (int i = 0; i < frameBuf.size(); i++) begin
            if (underrunAt > 0 && i == underrunAt) begin
                inValid[s] = 1'b0;
                inLast[s]  = 1'b0;
                @(negedge clk);
            end
            applyStimulus(s, frameBuf[i], (i == frameBuf.size() - 1));
        end
    endtask

    task automatic waitDrain(input int s);
        int n;
        n = 0;
        while (qSize(s) != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        repeat (IFG_LEN + 3) @(negedge clk);
        checkOutput($sformatf("drain%0d", s), qSize(s), 0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no end of test, expected finish before 1 ms");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] hand [4];
        hand = '{8'h26, 8'h39, 8'hF4, 8'hCB};
        rstN = 1'b0;
        idleInputs(0);
        idleInputs(1);
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            checkOutput($sformatf("reset%0d", s),
                        {19'd0, inReady[s], txAbort[s], txDone[s], txCtl[s], txData[s]}, 32'd0);
        end
        #2 rstN = 1'b1;
        @(negedge clk);

        $display("[TB] unpadded \"123456789\" with hand-computed FCS");
        pushPre(1);
        for (int i = 0; i < 9; i++) pushExp(1, {2'b00, 2'b11, 8'(8'h31 + i)});
        for (int i = 0; i < 4; i++) pushExp(1, {1'b0, (i == 3), 2'b11, hand[i]});
        buildFrame(9, 8'h31 - 0);
        for (int i = 0; i < 9; i++) frameBuf[i] = 8'(8'h31 + i);
        driveFrame(1, 0);
        idleInputs(1);
        waitDrain(1);

        $display("[TB] short frame padded to minimum length");
        buildFrame(10, 8'hA0);
        pushFrame(0, 0);
        driveFrame(0, 0);
        idleInputs(0);
        waitDrain(0);

        $display("[TB] underrun after 20 bytes, drain to in_last");
        buildFrame(30, 8'h11);
        pushFrame(0, 20);
        driveFrame(0, 20);
        idleInputs(0);
        waitDrain(0);

        $display("[TB] oversize and maximum-size frames");
        buildFrame(MAX_LEN + 1, 8'h05);
        pushFrame(0, 0);
        driveFrame(0, 0);
        idleInputs(0);
        waitDrain(0);
        buildFrame(MAX_LEN, 8'h3C);
        pushFrame(0, 0);
        driveFrame(0, 0);
        idleInputs(0);
        waitDrain(0);

        $display("[TB] two 64-byte frames back-to-back");
        buildFrame(64, 8'h22);
        pushFrame(0, 0);
        driveFrame(0, 0);
        buildFrame(64, 8'h77);
        pushFrame(0, 0);
        driveFrame(0, 0);
        idleInputs(0);
        waitDrain(0);
        checkOutput("b2bGap", gapLast, IFG_LEN + 1);

        $display("[TB] reset in the middle of data");
        buildFrame(40, 8'h5A);
        pushPre(0);
        for (int i = 0; i < 15; i++) pushExp(0, {2'b00, 2'b11, frameBuf[i]});
        for (int i = 0; i < 15; i++) applyStimulus(0, frameBuf[i], 1'b0);
        #2 rstN = 1'b0;
        idleInputs(0);
        #1;
        checkOutput("resetMid", {19'd0, inReady[0], txAbort[0], txDone[0], txCtl[0], txData[0]}, 32'd0);
        checkOutput("preResetQ", qSize(0), 0);
        expQ0.delete();
        repeat (3) @(negedge clk);
        #2 rstN = 1'b1;
        @(negedge clk);
        buildFrame(20, 8'hC3);
        pushFrame(0, 0);
        driveFrame(0, 0);
        idleInputs(0);
        waitDrain(0);

        checkOutput("finalQ1", qSize(1), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
